// File: rtl/rand_gen_arb_pkg.sv
// ----------------------------------------------------------------------------
// rand_gen_arb_pkg
// Shared types and helpers for the rand_gen round-robin arbiter.
//   t_arb_state : arbiter FSM state encoding
//   MAX_REQ     : largest supported requester count
//   t_req_idx   : requester index wide enough for MAX_REQ requesters
//   rr_next     : pointer increment that wraps modulo n
// ----------------------------------------------------------------------------
package rand_gen_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] t_req_idx;

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_busy,
    e_resp
  } t_arb_state;

  // Next round-robin position after idx among n requesters.
  function automatic t_req_idx rr_next(input t_req_idx idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + t_req_idx'(1);
  endfunction

endpackage

// File: rtl/rand_gen_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: picks the first active request at or
// after the pointer, wrapping to requester 0.
// Ports:
//   i_req   [NUM_REQ]  request levels
//   i_ptr              round-robin start position
//   o_grant [NUM_REQ]  one-hot winner (all zero when no request)
//   o_idx              index of the winner
//   o_any              at least one request is active
// ----------------------------------------------------------------------------
module rr_picker
  import rand_gen_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  t_req_idx           i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output t_req_idx           o_idx,
  output logic               o_any
);

  logic found;

  // Two passes avoid a barrel rotate: first the upper segment [ptr, N-1],
  // then the wrapped segment starting at 0.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    found   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && i_req[j] && (t_req_idx'(j) >= i_ptr)) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = t_req_idx'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && i_req[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = t_req_idx'(j);
      end
    end
  end

endmodule

// File: rtl/rand_gen_arbiter.sv
// ----------------------------------------------------------------------------
// rand_gen_arbiter
// Shares one rand_gen between NUM_REQ requesters with round-robin arbitration.
// Sequences rand_gen through generate/ready/done and routes the result back
// to the granted requester only.
//
// Optional feature: define RAND_ARB_TIMEOUT_EN to add a BUSY watchdog that
// completes the transaction as invalid after TIMEOUT_CYC cycles.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req   [NUM_REQ]   request levels, held until the matching o_done
//   i_upper/i_lower     packed per-requester bounds, slice k = [k*VAL_W +: VAL_W]
//   o_grant [NUM_REQ]   one-hot owner of rand_gen
//   o_done  [NUM_REQ]   one-cycle result pulse
//   o_invalid[NUM_REQ]  qualifies o_done (bounds rejected or timeout)
//   o_val               result, valid in the o_done cycle
//   o_gen               rand_gen generate pulse
//   o_gen_upper/lower   bounds to rand_gen, stable from ISSUE to RESP
//   i_gen_ready/done/invalid/val  rand_gen status and result
// ----------------------------------------------------------------------------
module rand_gen_arbiter
  import rand_gen_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int VAL_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*VAL_W-1:0] i_upper,
  input  logic [NUM_REQ*VAL_W-1:0] i_lower,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REQ-1:0]       o_invalid,
  output logic [VAL_W-1:0]         o_val,
  output logic                     o_gen,
  output logic [VAL_W-1:0]         o_gen_upper,
  output logic [VAL_W-1:0]         o_gen_lower,
  input  logic                     i_gen_ready,
  input  logic                     i_gen_done,
  input  logic                     i_gen_invalid,
  input  logic [VAL_W-1:0]         i_gen_val
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rand_gen_arbiter: unsupported parameter set");
  end

  t_arb_state         state_q, state_d;
  t_req_idx           rr_q, rr_d;
  t_req_idx           idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] invalid_q, invalid_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic               gen_q, gen_d;
  logic [VAL_W-1:0]   upper_q, upper_d;
  logic [VAL_W-1:0]   lower_q, lower_d;

  logic [NUM_REQ-1:0] pick_grant;
  t_req_idx           pick_idx;
  logic               pick_any;

`ifdef RAND_ARB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (rr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    // Pulse-style outputs fall back to zero unless a transition asserts them.
    done_d    = '0;
    invalid_d = '0;
    val_d     = '0;
    gen_d     = 1'b0;
`ifdef RAND_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      e_idle: begin
        if (pick_any && i_gen_ready) begin
          state_d = e_issue;
          idx_d   = pick_idx;
          grant_d = pick_grant;
          gen_d   = 1'b1;
          // Bounds are captured here so the requester may change them freely.
          for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_grant[j]) begin
              upper_d = i_upper[j*VAL_W +: VAL_W];
              lower_d = i_lower[j*VAL_W +: VAL_W];
            end
          end
        end
      end

      e_issue: begin
        state_d = e_busy;
`ifdef RAND_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      e_busy: begin
        if (i_gen_done) begin
          state_d   = e_resp;
          grant_d   = '0;
          done_d    = grant_q;
          invalid_d = i_gen_invalid ? grant_q : '0;
          val_d     = i_gen_val;
        end
`ifdef RAND_ARB_TIMEOUT_EN
        else if (cnt_q + CNT_W'(1) == CNT_LIMIT) begin
          state_d   = e_resp;
          grant_d   = '0;
          done_d    = grant_q;
          invalid_d = grant_q;
          val_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      e_resp: begin
        state_d = e_idle;
        rr_d    = rr_next(idx_q, NUM_REQ);
      end

      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      state_q   <= e_idle;
      rr_q      <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      invalid_q <= '0;
      val_q     <= '0;
      gen_q     <= 1'b0;
      upper_q   <= '0;
      lower_q   <= '0;
`ifdef RAND_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      val_q     <= val_d;
      gen_q     <= gen_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
`ifdef RAND_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_invalid   = invalid_q;
  assign o_val       = val_q;
  assign o_gen       = gen_q;
  assign o_gen_upper = upper_q;
  assign o_gen_lower = lower_q;

endmodule

// File: tb/tb_rand_gen_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rand_gen_arbiter
// Bench for rand_gen_arbiter with a 5-cycle rand_gen stand-in returning
// lower+3 (invalid when upper < lower). Build with RAND_ARB_TIMEOUT_EN to
// include the watchdog scenario.
// ----------------------------------------------------------------------------
module tb_rand_gen_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] upper, lower;
  logic [N-1:0]   o_grant, o_done, o_invalid;
  logic [W-1:0]   o_val, o_gen_upper, o_gen_lower;
  logic           o_gen;
  logic           gen_ready;

  // rand_gen stand-in
  logic         ready_en, never_done;
  logic         mbusy, mdone, minv;
  logic [W-1:0] mval, mu, ml;
  int           lat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign gen_ready = ready_en && !mbusy;

  rand_gen_arbiter #(
    .NUM_REQ     (N),
    .VAL_W       (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_upper       (upper),
    .i_lower       (lower),
    .o_grant       (o_grant),
    .o_done        (o_done),
    .o_invalid     (o_invalid),
    .o_val         (o_val),
    .o_gen         (o_gen),
    .o_gen_upper   (o_gen_upper),
    .o_gen_lower   (o_gen_lower),
    .i_gen_ready   (gen_ready),
    .i_gen_done    (mdone),
    .i_gen_invalid (minv),
    .i_gen_val     (mval)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // rand_gen stand-in: done appears 5 edges after the edge that sees o_gen.
  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
      minv  <= 1'b0;
      mval  <= '0;
      lat   <= 0;
    end else begin
      mdone <= 1'b0;
      if (!mbusy && o_gen) begin
        mbusy <= 1'b1;
        lat   <= 4;
        mu    <= o_gen_upper;
        ml    <= o_gen_lower;
      end else if (mbusy && !never_done) begin
        if (lat == 0) begin
          mdone <= 1'b1;
          mbusy <= 1'b0;
          mval  <= ml + 32'd3;
          minv  <= (mu < ml);
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // Inputs as seen by the DUT at each rising edge.
  logic [N-1:0]   req_s;
  logic [N*W-1:0] upper_s, lower_s;
  logic           ready_s;
  logic           rst_s = 1'b1;

  always @(posedge clk) begin
    req_s   <= req;
    upper_s <= upper;
    lower_s <= lower;
    ready_s <= gen_ready;
    rst_s   <= rst;
    cyc     <= cyc + 1;
  end

  // Transaction-level reference: pointer, current owner, result routing.
  int           m_ptr, m_cur, m_age, m_gen_count;
  logic         m_in_txn, m_prev_done, m_gdone, m_ginv;
  logic [W-1:0] m_gval, m_last_up, m_last_lo;
  logic         arb_ok, exp_done, exp_inv;
  logic [W-1:0] exp_val;

  initial begin
    m_ptr = 0; m_cur = 0; m_age = 0; m_gen_count = 0;
    m_in_txn = 1'b0; m_prev_done = 1'b0; m_gdone = 1'b0; m_ginv = 1'b0;
    m_gval = '0; m_last_up = '0; m_last_lo = '0;
  end

  always @(negedge clk) begin
    if (rst_s) begin
      check("rst_grant", o_grant, 0);
      check("rst_done", o_done, 0);
      check("rst_gen", o_gen, 0);
      m_ptr = 0; m_in_txn = 1'b0; m_prev_done = 1'b0; m_gdone = 1'b0;
    end else begin
      arb_ok = !m_in_txn && !m_prev_done && (req_s != '0) && ready_s;
      check("gen_pulse", o_gen, arb_ok);
      exp_done = 1'b0;
      exp_inv  = 1'b0;
      exp_val  = '0;
      if (m_in_txn) begin
        m_age++;
        if (m_gdone) begin
          exp_done = 1'b1;
          exp_inv  = m_ginv;
          exp_val  = m_gval;
        end
`ifdef RAND_ARB_TIMEOUT_EN
        else if (m_age == TO + 1) begin
          exp_done = 1'b1;
          exp_inv  = 1'b1;
        end
`endif
      end
      if (arb_ok) begin
        m_cur    = pick(req_s, m_ptr);
        m_in_txn = 1'b1;
        m_age    = 0;
        check("gen_upper", o_gen_upper, upper_s[m_cur*W +: W]);
        check("gen_lower", o_gen_lower, lower_s[m_cur*W +: W]);
      end
      if (o_gen) begin
        m_gen_count++;
        m_last_up = o_gen_upper;
        m_last_lo = o_gen_lower;
      end
      check("done", o_done, exp_done ? onehot(m_cur) : '0);
      check("invalid", o_invalid, exp_inv ? onehot(m_cur) : '0);
      if (exp_done) begin
        check("val", o_val, exp_val);
        m_in_txn = 1'b0;
        m_ptr    = (m_cur + 1) % N;
      end
      check("grant", o_grant, m_in_txn ? onehot(m_cur) : '0);
      m_prev_done = exp_done;
      m_gdone     = mdone;
      m_gval      = mval;
      m_ginv      = minv;
    end
  end

  task automatic set_bounds(input int k, input logic [W-1:0] up, input logic [W-1:0] lo);
    upper[k*W +: W] = up;
    lower[k*W +: W] = lo;
  endtask

  task automatic wait_done(input string name, output int k, output logic [W-1:0] v,
                           output logic inv);
    k   = -1;
    v   = '0;
    inv = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (|o_done) begin
        for (int j = 0; j < N; j++) if (o_done[j]) k = j;
        v   = o_val;
        inv = |o_invalid;
        return;
      end
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_gen(input string name);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (o_gen) return;
    end
    check({name, "_gen_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           k, t0, cnt;
    logic [W-1:0] v;
    logic         inv;
    int           order[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
    int           exp_vals[8] = '{8, 108, 208, 308, 8, 108, 208, 308};

    rst = 1'b1; req = '0; upper = '0; lower = '0;
    ready_en = 1'b1; never_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_val", o_val, 0);
    check("init_gen_upper", o_gen_upper, 0);
    check("init_gen_lower", o_gen_lower, 0);
    check("init_invalid", o_invalid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single request on requester 2
    set_bounds(2, 32'd15000, 32'd2000);
    cnt = m_gen_count;
    t0  = cyc;
    req = 4'b0100;
    wait_done("t1", k, v, inv);
    check("t1_idx", k, 2);
    check("t1_val", v, 2003);
    check("t1_inv", inv, 0);
    check("t1_latency", cyc - t0, 8);
    check("t1_grant_after", o_grant, 0);
    check("t1_gen_count", m_gen_count - cnt, 1);
    check("t1_gen_upper", m_last_up, 15000);
    check("t1_gen_lower", m_last_lo, 2000);
    req = '0;
    repeat (2) @(negedge clk);

    // Test 2: all requesters held, eight rounds in round-robin order
    do_reset();
    for (int j = 0; j < N; j++) set_bounds(j, 32'(j*100 + 500), 32'(j*100 + 5));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_done("t2", k, v, inv);
      check("t2_order", k, order[i]);
      check("t2_val", v, exp_vals[i]);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Test 3: swapped bounds rejected by rand_gen
    set_bounds(1, 32'd10, 32'd20);
    req = 4'b0010;
    wait_done("t3", k, v, inv);
    check("t3_idx", k, 1);
    check("t3_inv", inv, 1);
    check("t3_inv_vec", o_invalid, 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);

    // Test 4: rand_gen not ready stalls arbitration
    ready_en = 1'b0;
    req      = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_stall_grant", o_grant, 0);
      check("t4_stall_gen", o_gen, 0);
    end
    ready_en = 1'b1;
    @(negedge clk);
    check("t4_grant_on_ready", o_grant, 4'b0001);
    check("t4_gen_on_ready", o_gen, 1);
    wait_done("t4", k, v, inv);
    check("t4_idx", k, 0);
    req = '0;
    repeat (2) @(negedge clk);

    // Test 5: reset while BUSY abandons the transaction
    req = 4'b0100;
    wait_gen("t5");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("t5_grant", o_grant, 0);
    check("t5_done", o_done, 0);
    check("t5_invalid", o_invalid, 0);
    check("t5_val", o_val, 0);
    check("t5_gen", o_gen, 0);
    check("t5_gen_upper", o_gen_upper, 0);
    check("t5_gen_lower", o_gen_lower, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|o_done) cnt++;
    end
    check("t5_no_done", cnt, 0);
    req = 4'b1001;
    wait_done("t5_after", k, v, inv);
    check("t5_ptr_restart", k, 0);
    req = '0;
    repeat (2) @(negedge clk);

`ifdef RAND_ARB_TIMEOUT_EN
    // Test 6: rand_gen never answers; watchdog completes as invalid
    never_done = 1'b1;
    req        = 4'b0001;
    wait_gen("t6");
    t0 = cyc;
    wait_done("t6", k, v, inv);
    check("t6_idx", k, 0);
    check("t6_inv", inv, 1);
    check("t6_val", v, 0);
    check("t6_latency", cyc - t0, TO + 1);
    req = '0;
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
